// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue/writeback stage: widths, op codes,
// FSM state encoding and instruction field layout.
package alu_issue_pkg;

  localparam int DW   = 4;
  localparam int NREG = 4;
  localparam int RW   = 2;
  localparam int OPW  = 3;
  localparam int IW   = OPW + 3 * RW;

  localparam logic [OPW-1:0] OP_ZERO  = 3'd0;
  localparam logic [OPW-1:0] OP_BSUBA = 3'd1;
  localparam logic [OPW-1:0] OP_ASUBB = 3'd2;
  localparam logic [OPW-1:0] OP_ADD   = 3'd3;
  localparam logic [OPW-1:0] OP_XOR   = 3'd4;
  localparam logic [OPW-1:0] OP_OR    = 3'd5;
  localparam logic [OPW-1:0] OP_AND   = 3'd6;
  localparam logic [OPW-1:0] OP_ONES  = 3'd7;

  localparam int OP_MSB = 8;
  localparam int OP_LSB = 6;
  localparam int RD_MSB = 5;
  localparam int RD_LSB = 4;
  localparam int RA_MSB = 3;
  localparam int RA_LSB = 2;
  localparam int RB_MSB = 1;
  localparam int RB_LSB = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic [OPW-1:0] instr_op(input logic [IW-1:0] i);
    return i[OP_MSB:OP_LSB];
  endfunction

  function automatic logic [RW-1:0] instr_rd(input logic [IW-1:0] i);
    return i[RD_MSB:RD_LSB];
  endfunction

  function automatic logic [RW-1:0] instr_ra(input logic [IW-1:0] i);
    return i[RA_MSB:RA_LSB];
  endfunction

  function automatic logic [RW-1:0] instr_rb(input logic [IW-1:0] i);
    return i[RB_MSB:RB_LSB];
  endfunction

endpackage

// File: rtl/alu_issue_regfile.sv
// Small register file for the issue stage: two asynchronous read ports and a
// single synchronous write port shared by the direct load path and ALU
// writeback, with the load taking priority.
module issue_regfile
  import alu_issue_pkg::*;
(
  input  logic          clk,
  input  logic          resetn,
  input  logic          ld_en,
  input  logic [RW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  input  logic          wb_en,
  input  logic [RW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  input  logic [RW-1:0] ra_addr,
  output logic [DW-1:0] ra_data,
  input  logic [RW-1:0] rb_addr,
  output logic [DW-1:0] rb_data
);

  logic [DW-1:0] regs [NREG];
  logic          we;
  logic [RW-1:0] waddr;
  logic [DW-1:0] wdata;

  // Select the write source; a direct load overrides a writeback
  always_comb begin
    we    = ld_en | wb_en;
    waddr = wb_addr;
    wdata = wb_data;
    if (ld_en) begin
      waddr = ld_addr;
      wdata = ld_data;
    end
  end

  // Register storage, cleared on reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign ra_data = regs[ra_addr];
  assign rb_data = regs[rb_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback stage in front of the 4-bit combinational ALU. Accepts an
// instruction, drives the ALU for one cycle from the register file, writes
// the result back and holds it for a downstream consumer.
module alu_issue_ctrl
  import alu_issue_pkg::*;
(
  input  logic           Clock,
  input  logic           Resetn,
  input  logic           instr_valid,
  output logic           instr_ready,
  input  logic [IW-1:0]  instr,
  input  logic           ld_en,
  input  logic [RW-1:0]  ld_addr,
  input  logic [DW-1:0]  ld_data,
  output logic [OPW-1:0] alu_S,
  output logic [DW-1:0]  alu_A,
  output logic [DW-1:0]  alu_B,
  input  logic [DW-1:0]  alu_F,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [DW-1:0]  res_data,
  output logic [RW-1:0]  res_rd,
  output logic           res_zero,
  output logic           busy
);

  state_t        state;
  state_t        next_state;
  logic [IW-1:0] ir;
  logic          accept;
  logic          ld_ok;
  logic          wb_en;
  logic [DW-1:0] rdata_a;
  logic [DW-1:0] rdata_b;

  issue_regfile u_rf (
    .clk     (Clock),
    .resetn  (Resetn),
    .ld_en   (ld_ok),
    .ld_addr (ld_addr),
    .ld_data (ld_data),
    .wb_en   (wb_en),
    .wb_addr (instr_rd(ir)),
    .wb_data (alu_F),
    .ra_addr (instr_ra(ir)),
    .ra_data (rdata_a),
    .rb_addr (instr_rb(ir)),
    .rb_data (rdata_b)
  );

  // Next-state, handshake and load-gating decode
  always_comb begin
    next_state  = state;
    instr_ready = 1'b0;
    ld_ok       = 1'b0;
    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        ld_ok       = ld_en;
        if (instr_valid) next_state = ISSUE;
      end
      ISSUE: begin
        next_state = DONE;
      end
      DONE: begin
        instr_ready = res_ready;
        ld_ok       = ld_en & ~(res_ready & instr_valid);
        if (res_ready) next_state = instr_valid ? ISSUE : IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  assign accept = instr_valid & instr_ready;
  assign wb_en  = (state == ISSUE);
  assign busy   = (state != IDLE);

  // ALU inputs are only live during ISSUE so the ALU sees zeros otherwise
  always_comb begin
    alu_S = '0;
    alu_A = '0;
    alu_B = '0;
    if (state == ISSUE) begin
      alu_S = instr_op(ir);
      alu_A = rdata_a;
      alu_B = rdata_b;
    end
  end

  // FSM state register
  always_ff @(posedge Clock) begin
    if (!Resetn) state <= IDLE;
    else         state <= next_state;
  end

  // Instruction capture and result register
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      ir        <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_rd    <= '0;
      res_zero  <= 1'b1;
    end else begin
      if (accept) ir <= instr;
      if (state == ISSUE) begin
        res_data  <= alu_F;
        res_rd    <= instr_rd(ir);
        res_zero  <= (alu_F == '0);
        res_valid <= 1'b1;
      end else if (state == DONE && res_ready && !instr_valid) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed self-checking bench for alu_issue_ctrl with a behavioural model
// of the 4-bit ALU closing the loop on alu_S/alu_A/alu_B -> alu_F.
module tb_alu_issue_ctrl;

  logic       Clock;
  logic       Resetn;
  logic       instr_valid;
  logic       instr_ready;
  logic [8:0] instr;
  logic       ld_en;
  logic [1:0] ld_addr;
  logic [3:0] ld_data;
  logic [2:0] alu_S;
  logic [3:0] alu_A;
  logic [3:0] alu_B;
  logic [3:0] alu_F;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_data;
  logic [1:0] res_rd;
  logic       res_zero;
  logic       busy;

  int vectors;
  int miscompares;

  alu_issue_ctrl dut (
    .Clock       (Clock),
    .Resetn      (Resetn),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .ld_en       (ld_en),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .alu_S       (alu_S),
    .alu_A       (alu_A),
    .alu_B       (alu_B),
    .alu_F       (alu_F),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_rd      (res_rd),
    .res_zero    (res_zero),
    .busy        (busy)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Reference model of the downstream ALU
  always_comb begin
    alu_F = 4'h0;
    case (alu_S)
      3'd0: alu_F = 4'h0;
      3'd1: alu_F = alu_B - alu_A;
      3'd2: alu_F = alu_A - alu_B;
      3'd3: alu_F = alu_A + alu_B;
      3'd4: alu_F = alu_A ^ alu_B;
      3'd5: alu_F = alu_A | alu_B;
      3'd6: alu_F = alu_A & alu_B;
      default: alu_F = 4'hF;
    endcase
  end

  function automatic logic [8:0] mk(input logic [2:0] op, input logic [1:0] rd,
                                    input logic [1:0] ra, input logic [1:0] rb);
    return {op, rd, ra, rb};
  endfunction

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic applyStimulus(input logic iv, input logic [8:0] ins, input logic le,
                               input logic [1:0] la, input logic [3:0] ld, input logic rr);
    instr_valid = iv;
    instr       = ins;
    ld_en       = le;
    ld_addr     = la;
    ld_data     = ld;
    res_ready   = rr;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    Resetn      = 1'b0;
    applyStimulus(1'b0, 9'h0, 1'b0, 2'd0, 4'h0, 1'b1);

    $display("[TB] reset");
    step();
    step();
    checkOutput("rst_instr_ready", {7'd0, instr_ready}, 8'd1);
    checkOutput("rst_res_valid", {7'd0, res_valid}, 8'd0);
    checkOutput("rst_busy", {7'd0, busy}, 8'd0);
    checkOutput("rst_res_zero", {7'd0, res_zero}, 8'd1);
    checkOutput("rst_res_data", {4'd0, res_data}, 8'h0);
    checkOutput("rst_alu_S", {5'd0, alu_S}, 8'd0);
    Resetn = 1'b1;

    $display("[TB] OR on cleared registers");
    applyStimulus(1'b1, mk(3'd5, 2'd0, 2'd1, 2'd2), 1'b0, 2'd0, 4'h0, 1'b1);
    step();
    applyStimulus(1'b0, 9'h0, 1'b0, 2'd0, 4'h0, 1'b1);
    checkOutput("t1_busy", {7'd0, busy}, 8'd1);
    checkOutput("t1_instr_ready", {7'd0, instr_ready}, 8'd0);
    checkOutput("t1_alu_S", {5'd0, alu_S}, 8'd5);
    step();
    checkOutput("t1_res_valid", {7'd0, res_valid}, 8'd1);
    checkOutput("t1_res_data", {4'd0, res_data}, 8'h0);
    checkOutput("t1_res_zero", {7'd0, res_zero}, 8'd1);
    step();
    checkOutput("t1_idle_valid", {7'd0, res_valid}, 8'd0);

    $display("[TB] load and add");
    applyStimulus(1'b0, 9'h0, 1'b1, 2'd1, 4'h9, 1'b1);
    step();
    applyStimulus(1'b0, 9'h0, 1'b1, 2'd2, 4'h5, 1'b1);
    step();
    applyStimulus(1'b1, mk(3'd3, 2'd3, 2'd1, 2'd2), 1'b0, 2'd0, 4'h0, 1'b1);
    step();
    applyStimulus(1'b0, 9'h0, 1'b0, 2'd0, 4'h0, 1'b1);
    checkOutput("t2_alu_S", {5'd0, alu_S}, 8'd3);
    checkOutput("t2_alu_A", {4'd0, alu_A}, 8'h9);
    checkOutput("t2_alu_B", {4'd0, alu_B}, 8'h5);
    step();
    checkOutput("t2_res_valid", {7'd0, res_valid}, 8'd1);
    checkOutput("t2_res_data", {4'd0, res_data}, 8'hE);
    checkOutput("t2_res_rd", {6'd0, res_rd}, 8'd3);
    checkOutput("t2_res_zero", {7'd0, res_zero}, 8'd0);
    checkOutput("t2_R3", {4'd0, dut.u_rf.regs[3]}, 8'hE);
    step();

    $display("[TB] wrap, load with accept, subtract with hazard");
    applyStimulus(1'b0, 9'h0, 1'b1, 2'd1, 4'hC, 1'b1);
    step();
    applyStimulus(1'b1, mk(3'd3, 2'd0, 2'd1, 2'd2), 1'b1, 2'd2, 4'h7, 1'b1);
    step();
    applyStimulus(1'b0, 9'h0, 1'b0, 2'd0, 4'h0, 1'b1);
    checkOutput("t3_alu_A", {4'd0, alu_A}, 8'hC);
    checkOutput("t3_alu_B_loaded", {4'd0, alu_B}, 8'h7);
    step();
    checkOutput("t3_add_wrap", {4'd0, res_data}, 8'h3);
    checkOutput("t3_res_rd", {6'd0, res_rd}, 8'd0);
    applyStimulus(1'b1, mk(3'd1, 2'd2, 2'd1, 2'd0), 1'b0, 2'd0, 4'h0, 1'b1);
    checkOutput("t3_done_ready", {7'd0, instr_ready}, 8'd1);
    step();
    applyStimulus(1'b0, 9'h0, 1'b0, 2'd0, 4'h0, 1'b1);
    checkOutput("t3_hazard_B", {4'd0, alu_B}, 8'h3);
    step();
    checkOutput("t3_bsuba", {4'd0, res_data}, 8'h7);
    checkOutput("t3_res_rd2", {6'd0, res_rd}, 8'd2);
    checkOutput("t3_R2", {4'd0, dut.u_rf.regs[2]}, 8'h7);

    $display("[TB] backpressure");
    applyStimulus(1'b1, mk(3'd3, 2'd3, 2'd1, 2'd0), 1'b1, 2'd2, 4'hA, 1'b0);
    checkOutput("t4_instr_ready", {7'd0, instr_ready}, 8'd0);
    step();
    checkOutput("t4_load_wins", {4'd0, dut.u_rf.regs[2]}, 8'hA);
    checkOutput("t4_res_data_kept", {4'd0, res_data}, 8'h7);
    applyStimulus(1'b1, mk(3'd3, 2'd3, 2'd1, 2'd0), 1'b0, 2'd0, 4'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      checkOutput("t4_hold_valid", {7'd0, res_valid}, 8'd1);
      checkOutput("t4_hold_data", {4'd0, res_data}, 8'h7);
      checkOutput("t4_hold_ready", {7'd0, instr_ready}, 8'd0);
      checkOutput("t4_no_issue", {5'd0, alu_S}, 8'd0);
    end
    applyStimulus(1'b1, mk(3'd3, 2'd3, 2'd1, 2'd0), 1'b1, 2'd1, 4'h0, 1'b1);
    checkOutput("t4_release_ready", {7'd0, instr_ready}, 8'd1);
    step();
    applyStimulus(1'b0, 9'h0, 1'b0, 2'd0, 4'h0, 1'b1);
    checkOutput("t4_issue_S", {5'd0, alu_S}, 8'd3);
    checkOutput("t4_load_ignored_A", {4'd0, alu_A}, 8'hC);
    checkOutput("t4_issue_B", {4'd0, alu_B}, 8'h3);
    step();
    checkOutput("t4_new_valid", {7'd0, res_valid}, 8'd1);
    checkOutput("t4_new_data", {4'd0, res_data}, 8'hF);
    checkOutput("t4_new_rd", {6'd0, res_rd}, 8'd3);

    $display("[TB] dependency and zero");
    applyStimulus(1'b1, mk(3'd2, 2'd1, 2'd1, 2'd1), 1'b0, 2'd0, 4'h0, 1'b1);
    step();
    applyStimulus(1'b1, mk(3'd7, 2'd2, 2'd1, 2'd1), 1'b0, 2'd0, 4'h0, 1'b1);
    checkOutput("t5_busy_issue_ready", {7'd0, instr_ready}, 8'd0);
    step();
    checkOutput("t5_asubb", {4'd0, res_data}, 8'h0);
    checkOutput("t5_zero", {7'd0, res_zero}, 8'd1);
    checkOutput("t5_R1", {4'd0, dut.u_rf.regs[1]}, 8'h0);
    step();
    applyStimulus(1'b0, 9'h0, 1'b0, 2'd0, 4'h0, 1'b1);
    checkOutput("t5_ones_S", {5'd0, alu_S}, 8'd7);
    step();
    checkOutput("t5_ones", {4'd0, res_data}, 8'hF);
    checkOutput("t5_ones_zero", {7'd0, res_zero}, 8'd0);
    checkOutput("t5_R2", {4'd0, dut.u_rf.regs[2]}, 8'hF);
    step();
    checkOutput("t5_idle_valid", {7'd0, res_valid}, 8'd0);
    checkOutput("t5_idle_busy", {7'd0, busy}, 8'd0);

    $display("[TB] reset during ISSUE");
    applyStimulus(1'b1, mk(3'd3, 2'd3, 2'd1, 2'd2), 1'b0, 2'd0, 4'h0, 1'b1);
    step();
    applyStimulus(1'b0, 9'h0, 1'b0, 2'd0, 4'h0, 1'b1);
    checkOutput("t6_in_issue", {7'd0, busy}, 8'd1);
    Resetn = 1'b0;
    step();
    checkOutput("t6_busy", {7'd0, busy}, 8'd0);
    checkOutput("t6_res_valid", {7'd0, res_valid}, 8'd0);
    checkOutput("t6_R3", {4'd0, dut.u_rf.regs[3]}, 8'h0);
    checkOutput("t6_res_data", {4'd0, res_data}, 8'h0);
    checkOutput("t6_res_zero", {7'd0, res_zero}, 8'd1);
    Resetn = 1'b1;
    step();
    checkOutput("t6_stay_idle", {7'd0, busy}, 8'd0);
    checkOutput("t6_stay_invalid", {7'd0, res_valid}, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
